// File: rtl/hamming_pkg.sv
// Shared definitions for the Hamming weight / distance unit.
// Holds the FSM state encoding, the operation mode encoding and a small
// width helper used to size counters that must stay at least one bit wide.
package hamming_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic MODE_WEIGHT = 1'b0;
  localparam logic MODE_DIST   = 1'b1;

  // Index width for a counter of n values; never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Purpose: combinational population count of CHUNK bits as a balanced adder tree.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input continuously.
// Ports: bits_i - bits to count; count_o - number of ones in bits_i.
module popcount_chunk #(
  parameter  int unsigned CHUNK = 8,
  localparam int unsigned OUT_W = $clog2(CHUNK + 1)
) (
  input  logic [CHUNK-1:0] bits_i,
  output logic [OUT_W-1:0] count_o
);

  // Tree is stored as an implicit binary heap: node k has children 2k+1 and
  // 2k+2, leaves occupy the last LEAVES slots. Leaves beyond CHUNK are tied
  // to zero so the tree is always complete. Every partial sum is bounded by
  // CHUNK, so one width (OUT_W) suffices at every level.
  localparam int unsigned LEAVES = 1 << $clog2(CHUNK);
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic [OUT_W-1:0] node [NODES];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < CHUNK) begin : g_bit
      assign node[LEAVES-1+i] = OUT_W'(bits_i[i]);
    end else begin : g_pad
      assign node[LEAVES-1+i] = '0;
    end
  end

  for (genvar k = 0; k < LEAVES - 1; k++) begin : g_add
    assign node[k] = node[2*k+1] + node[2*k+2];
  end

  assign count_o = node[0];

endmodule

// File: rtl/hamming_weight_seq.sv
// Purpose: multi-cycle Hamming weight of a (mode=0) or Hamming distance a^b (mode=1), plus parity.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+BEATS; busy for BEATS cycles.
// Backpressure: start is only accepted in IDLE or DONE; start during RUN is dropped.
// Ports: clk/rst (sync, active-high); start, mode, a, b request; busy, done status;
//        weight/parity hold the last completed result until the next final beat.
module hamming_weight_seq
  import hamming_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned CHUNK = 8,
  localparam int unsigned BEATS = WIDTH / CHUNK,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] weight,
  output logic             parity
);

  localparam int unsigned PC_W   = $clog2(CHUNK + 1);
  localparam int unsigned BEAT_W = idx_w(BEATS);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("hamming_weight_seq: WIDTH must be a positive multiple of CHUNK");
  end

  state_e             state_q,  state_d;
  logic [WIDTH-1:0]   shift_q,  shift_d;
  logic [BEAT_W-1:0]  beat_q,   beat_d;
  logic [CNT_W-1:0]   acc_q,    acc_d;
  logic [CNT_W-1:0]   weight_q, weight_d;
  logic               parity_q, parity_d;

  logic [WIDTH-1:0]   operand;
  logic [PC_W-1:0]    chunk_cnt;
  logic [CNT_W-1:0]   acc_sum;
  logic               last_beat;

  // Only the low CHUNK bits of the shift register are counted each beat.
  popcount_chunk #(
    .CHUNK (CHUNK)
  ) u_popcount (
    .bits_i  (shift_q[CHUNK-1:0]),
    .count_o (chunk_cnt)
  );

  always_comb begin
    operand = a;
    case (mode)
      MODE_WEIGHT: operand = a;
      MODE_DIST:   operand = a ^ b;
      default:     operand = a;
    endcase
  end

  // Accumulator holds at most WIDTH, which CNT_W always covers.
  assign acc_sum   = acc_q + CNT_W'(chunk_cnt);
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    beat_d   = beat_q;
    acc_d    = acc_q;
    weight_d = weight_q;
    parity_d = parity_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          shift_d = operand;
          acc_d   = '0;
          beat_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d   = acc_sum;
        shift_d = shift_q >> CHUNK;
        beat_d  = beat_q + BEAT_W'(1);
        // Visible result only changes on the final beat; partial sums stay internal.
        if (last_beat) begin
          state_d  = S_DONE;
          weight_d = acc_sum;
          parity_d = acc_sum[0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      beat_q   <= '0;
      acc_q    <= '0;
      weight_q <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      beat_q   <= beat_d;
      acc_q    <= acc_d;
      weight_q <= weight_d;
      parity_q <= parity_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign weight = weight_q;
  assign parity = parity_q;

endmodule

// File: tb/tb_hamming_weight_seq.sv
// Directed bench for hamming_weight_seq at three parametrisations:
// 32/8 (main), 8/1 (one bit per beat) and 8/8 (single beat).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_hamming_weight_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        start32, mode32, busy32, done32, p32;
  logic [31:0] a32, b32;
  logic [5:0]  w32;

  logic        start8a, mode8a, busy8a, done8a, p8a;
  logic [7:0]  a8a, b8a;
  logic [3:0]  w8a;

  logic        start8b, mode8b, busy8b, done8b, p8b;
  logic [7:0]  a8b, b8b;
  logic [3:0]  w8b;

  hamming_weight_seq #(.WIDTH(32), .CHUNK(8)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode(mode32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .weight(w32), .parity(p32)
  );

  hamming_weight_seq #(.WIDTH(8), .CHUNK(1)) u_dut8a (
    .clk(clk), .rst(rst), .start(start8a), .mode(mode8a), .a(a8a), .b(b8a),
    .busy(busy8a), .done(done8a), .weight(w8a), .parity(p8a)
  );

  hamming_weight_seq #(.WIDTH(8), .CHUNK(8)) u_dut8b (
    .clk(clk), .rst(rst), .start(start8b), .mode(mode8b), .a(a8b), .b(b8b),
    .busy(busy8b), .done(done8b), .weight(w8b), .parity(p8b)
  );

  int n_cmp = 0;
  int n_err = 0;

  int         bc;
  int         dc;
  logic       seen, dn, p;
  logic [5:0] w;
  logic [3:0] w8;

  // Issue one op on the 32-bit unit and wait (bounded) for its done pulse.
  task automatic op32(input logic m, input logic [31:0] aa, input logic [31:0] bb,
                      output int bcy, output logic sn, output logic [5:0] wo,
                      output logic po, output logic dno);
    @(negedge clk);
    start32 = 1'b1; mode32 = m; a32 = aa; b32 = bb;
    @(negedge clk);
    start32 = 1'b0;
    bcy = 0; sn = 1'b0; wo = 'x; po = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (done32) begin
        sn = 1'b1; wo = w32; po = p32;
        break;
      end
      if (busy32) bcy++;
      @(negedge clk);
    end
    @(negedge clk);
    dno = done32;
  endtask

  // Same for the narrow units; sel=0 picks CHUNK=1, sel=1 picks CHUNK=8.
  task automatic op8(input bit sel, input logic m, input logic [7:0] aa, input logic [7:0] bb,
                     output int bcy, output logic sn, output logic [3:0] wo, output logic po);
    @(negedge clk);
    if (!sel) begin start8a = 1'b1; mode8a = m; a8a = aa; b8a = bb; end
    else      begin start8b = 1'b1; mode8b = m; a8b = aa; b8b = bb; end
    @(negedge clk);
    start8a = 1'b0; start8b = 1'b0;
    bcy = 0; sn = 1'b0; wo = 'x; po = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (sel ? done8b : done8a) begin
        sn = 1'b1;
        wo = sel ? w8b : w8a;
        po = sel ? p8b : p8a;
        break;
      end
      if (sel ? busy8b : busy8a) bcy++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start32 = 0; mode32 = 0; a32 = '0; b32 = '0;
    start8a = 0; mode8a = 0; a8a = '0; b8a = '0;
    start8b = 0; mode8b = 0; a8b = '0; b8b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy32); end
    n_cmp++; if (done32 !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done32); end
    n_cmp++; if (w32 !== 6'd0) begin n_err++; $display("FAIL reset_weight: got %0d want 0", w32); end
    n_cmp++; if (p32 !== 1'b0) begin n_err++; $display("FAIL reset_parity: got %b want 0", p32); end
    n_cmp++; if (w8a !== 4'd0 || busy8b !== 1'b0) begin
      n_err++; $display("FAIL reset_narrow: got w8a=%0d busy8b=%b want 0/0", w8a, busy8b);
    end
  endtask

  task automatic test_weight();
    op32(1'b0, 32'hFFFF_FFFF, 32'h0, bc, seen, w, p, dn);
    n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL ones_busy_cycles: got %0d want 4", bc); end
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL ones_done_seen: got %b want 1", seen); end
    n_cmp++; if (w !== 6'd32) begin n_err++; $display("FAIL ones_weight: got %0d want 32", w); end
    n_cmp++; if (p !== 1'b0) begin n_err++; $display("FAIL ones_parity: got %b want 0", p); end
    n_cmp++; if (dn !== 1'b0) begin n_err++; $display("FAIL ones_done_single: got %b want 0", dn); end
    op32(1'b0, 32'h0000_0007, 32'h0, bc, seen, w, p, dn);
    n_cmp++; if (w !== 6'd3) begin n_err++; $display("FAIL seven_weight: got %0d want 3", w); end
    n_cmp++; if (p !== 1'b1) begin n_err++; $display("FAIL seven_parity: got %b want 1", p); end
  endtask

  task automatic test_distance();
    op32(1'b1, 32'hF0F0_F0F0, 32'h0F0F_0F0F, bc, seen, w, p, dn);
    n_cmp++; if (w !== 6'd32) begin n_err++; $display("FAIL dist_full: got %0d want 32", w); end
    op32(1'b1, 32'h1234_5678, 32'h1234_5678, bc, seen, w, p, dn);
    n_cmp++; if (w !== 6'd0 || p !== 1'b0) begin
      n_err++; $display("FAIL dist_equal: got w=%0d p=%b want 0/0", w, p);
    end
    // b must be ignored in weight mode.
    op32(1'b0, 32'h0000_0001, 32'h0000_FFFF, bc, seen, w, p, dn);
    n_cmp++; if (w !== 6'd1 || p !== 1'b1) begin
      n_err++; $display("FAIL weight_ignores_b: got w=%0d p=%b want 1/1", w, p);
    end
  endtask

  task automatic test_ignore_start();
    @(negedge clk);
    start32 = 1'b1; mode32 = 1'b0; a32 = 32'h8000_0001; b32 = '0;
    @(negedge clk);
    start32 = 1'b0;
    n_cmp++; if (busy32 !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %b want 1", busy32); end
    n_cmp++; if (w32 !== 6'd1) begin n_err++; $display("FAIL ign_hold_prev: got %0d want 1", w32); end
    @(negedge clk);
    start32 = 1'b1; a32 = 32'hFFFF_FFFF;
    @(negedge clk);
    start32 = 1'b0;
    dc = 0; w = '0;
    for (int i = 0; i < 12; i++) begin
      if (done32) begin dc++; w = w32; end
      @(negedge clk);
    end
    n_cmp++; if (dc !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", dc); end
    n_cmp++; if (w !== 6'd2) begin n_err++; $display("FAIL ign_weight: got %0d want 2", w); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start32 = 1'b1; mode32 = 1'b0; a32 = 32'h0000_00FF; b32 = '0;
    @(negedge clk);
    a32 = 32'h0000_000F;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done32) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b1 || w32 !== 6'd8) begin
      n_err++; $display("FAIL b2b_first: got seen=%b w=%0d want 1/8", seen, w32);
    end
    @(negedge clk);
    n_cmp++; if (busy32 !== 1'b1 || done32 !== 1'b0) begin
      n_err++; $display("FAIL b2b_no_gap: got busy=%b done=%b want 1/0", busy32, done32);
    end
    start32 = 1'b0;
    bc = 1; seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done32) begin seen = 1'b1; break; end
      if (busy32) bc++;
    end
    n_cmp++; if (bc !== 4) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d want 4", bc); end
    n_cmp++; if (seen !== 1'b1 || w32 !== 6'd4 || p32 !== 1'b0) begin
      n_err++; $display("FAIL b2b_second: got seen=%b w=%0d p=%b want 1/4/0", seen, w32, p32);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    start32 = 1'b1; mode32 = 1'b0; a32 = 32'hFFFF_FFFF;
    @(negedge clk);
    start32 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (busy32 !== 1'b0 || done32 !== 1'b0) begin
      n_err++; $display("FAIL abort_flags: got busy=%b done=%b want 0/0", busy32, done32);
    end
    n_cmp++; if (w32 !== 6'd0 || p32 !== 1'b0) begin
      n_err++; $display("FAIL abort_result: got w=%0d p=%b want 0/0", w32, p32);
    end
    dc = 0;
    for (int i = 0; i < 8; i++) begin
      if (done32) dc++;
      @(negedge clk);
    end
    n_cmp++; if (dc !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dc); end
    // Reset coincident with start: start is dropped.
    rst = 1'b1; start32 = 1'b1;
    @(negedge clk);
    rst = 1'b0; start32 = 1'b0;
    n_cmp++; if (busy32 !== 1'b0) begin n_err++; $display("FAIL rst_beats_start: got %b want 0", busy32); end
    op32(1'b0, 32'h00FF_00FF, 32'h0, bc, seen, w, p, dn);
    n_cmp++; if (w !== 6'd16 || p !== 1'b0) begin
      n_err++; $display("FAIL after_abort: got w=%0d p=%b want 16/0", w, p);
    end
  endtask

  task automatic test_narrow();
    op8(1'b0, 1'b0, 8'hA5, 8'h00, bc, seen, w8, p);
    n_cmp++; if (bc !== 8) begin n_err++; $display("FAIL c1_busy_cycles: got %0d want 8", bc); end
    n_cmp++; if (w8 !== 4'd4 || p !== 1'b0) begin
      n_err++; $display("FAIL c1_weight: got w=%0d p=%b want 4/0", w8, p);
    end
    op8(1'b0, 1'b1, 8'hFF, 8'h0F, bc, seen, w8, p);
    n_cmp++; if (w8 !== 4'd4) begin n_err++; $display("FAIL c1_dist: got %0d want 4", w8); end
    op8(1'b1, 1'b0, 8'h01, 8'h00, bc, seen, w8, p);
    n_cmp++; if (bc !== 1) begin n_err++; $display("FAIL c8_busy_cycles: got %0d want 1", bc); end
    n_cmp++; if (w8 !== 4'd1 || p !== 1'b1) begin
      n_err++; $display("FAIL c8_weight: got w=%0d p=%b want 1/1", w8, p);
    end
    op8(1'b1, 1'b0, 8'hFE, 8'h00, bc, seen, w8, p);
    n_cmp++; if (w8 !== 4'd7 || p !== 1'b1) begin
      n_err++; $display("FAIL c8_seven: got w=%0d p=%b want 7/1", w8, p);
    end
  endtask

  initial begin
    test_reset();
    test_weight();
    test_distance();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/hamming_weight_seq.md
Name: hamming_weight_seq

Overview:
Multi-cycle Hamming weight / Hamming distance unit. It is the parametrised successor to the 8-bit combinational parity block. It takes a WIDTH-bit operand and processes CHUNK bits per cycle. It returns the population count plus the parity bit, or the distance between two operands. A start/busy/done handshake makes it usable as a multi-cycle functional unit next to the ALU.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits counted per cycle; 1 <= CHUNK <= WIDTH.
BEATS (localparam), WIDTH/CHUNK, number of accumulate cycles.
CNT_W (localparam), $clog2(WIDTH+1), width of the weight result.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE or DONE
mode  input  1  0 = weight of a; 1 = distance, i.e. weight of a^b
a  input  WIDTH  operand A, sampled with accepted start
b  input  WIDTH  operand B, sampled with accepted start; ignored when mode=0
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
weight  output  CNT_W  popcount result
parity  output  1  XOR of all operand bits; equals weight[0]

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; it wins over every other input.
- Reset values: state=IDLE, busy=0, done=0, weight=0, parity=0, shift register=0, beat counter=0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN: on edge with start=1.
  - Load shift register with mode ? a^b : a.
  - Clear accumulator; beat counter=0.
- RUN, each edge:
  - acc += popcount(shift[CHUNK-1:0]).
  - shift >>= CHUNK (zero fill).
  - beat counter increments.
- RUN -> DONE: on the edge that performs beat BEATS-1.
  - weight and parity take their final values on that same edge.
  - done=1 during the DONE cycle.
- DONE -> RUN if start=1 on that edge. This allows back-to-back operation with no idle gap; new operands are loaded as in IDLE.
- DONE -> IDLE otherwise.
- Latency: start accepted at edge E0; done is high in the cycle following edge E0+BEATS.
  - busy is high for exactly BEATS cycles.
  - Throughput: one result per BEATS+1 cycles.
- start while in RUN is ignored; a, b and mode changes have no effect until the next accepted start.
- Output hold:
  - weight and parity hold the last result through DONE and IDLE, until the next final beat.
  - They are not cleared at the next start.
  - While in RUN they show the previous result; the partial sum stays internal.
- Arithmetic:
  - The accumulator is CNT_W bits and never overflows (max WIDTH).
  - The chunk popcount is $clog2(CHUNK+1) bits, zero-extended before the add.
- Reset mid-RUN: abort. The next cycle shows IDLE with all outputs at reset values. No done pulse is produced.
- Reset coincident with start: reset wins; start is dropped.
- Degenerate CHUNK=WIDTH: BEATS=1, so busy is high for one cycle, then done.

Decomposition:
- Shared package/header hamming_pkg:
  - state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - mode encodings MODE_WEIGHT=1'b0, MODE_DIST=1'b1.
- One sub-module, popcount_chunk:
  - parametrised combinational popcount of CHUNK bits, built as a structural adder tree;
  - instantiated once in hamming_weight_seq.
- FSM, shift register, beat counter and accumulator stay in the top module.

Test Plan:
1. WIDTH=32, CHUNK=8, mode=0, a=0xFFFFFFFF, start at E0 -> busy high 4 cycles, done pulse after E4, weight=32, parity=0. Also a=0x00000007 -> weight=3, parity=1.
2. mode=1, a=0xF0F0F0F0, b=0x0F0F0F0F -> weight=32. Then a=b=0x12345678 -> weight=0, parity=0.
3. Start a=0x80000001 (expect 2); at E2 pulse start with a=0xFFFFFFFF -> ignored, result 2, single done pulse.
4. Back-to-back: start held high through DONE with a=0x0000000F -> second op loads in DONE cycle, busy reasserts with no IDLE cycle, second done after 4 more cycles, weight=4.
5. rst asserted on edge E2 of a RUN -> next cycle busy=0, done=0, weight=0, no done pulse. A following op with a=0x00FF00FF returns 16.
6. Re-parametrise WIDTH=8, CHUNK=1, a=0xA5 -> 8 busy cycles, weight=4, parity=0. Also WIDTH=8, CHUNK=8, a=0x01 -> 1 busy cycle, weight=1, parity=1.
